axil_stream_writer: RTL and testbench

- Upstream feeder for the CPU subsystem's external AXI-lite write slave port (the `ext_*` RAM-load/GPIO path).
- Accepts address/data write commands from a valid/ready stream, typically sourced by a switchboard queue.
- Issues each command as a single AXI-lite write transaction, with one transaction outstanding at a time.
- Counts completed and errored writes so the host can confirm program load and reset release.

---
 rtl/axil_stream_writer.sv | 178 +++++++++++++++++
 tb/tb_axil_stream_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_stream_writer.sv
// axil_stream_writer: turns a valid/ready stream of address/data write commands
// into single-beat AXI-lite writes, one transaction outstanding at a time, and
// keeps saturating counts of completed and errored writes.
// Optional build macro SB_AXIL_WR_RESP_EN adds a RESP state plus the
// resp_valid/resp_code/resp_ready response stream.
module axil_stream_writer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    input  logic [1:0]              m_axil_bresp,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    err_count
`ifdef SB_AXIL_WR_RESP_EN
    ,
    output logic                    resp_valid,
    output logic [1:0]              resp_code,
    input  logic                    resp_ready
`endif
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
`ifdef SB_AXIL_WR_RESP_EN
    logic                    resp_valid_q, resp_valid_d;
    logic [1:0]              resp_code_q, resp_code_d;
`endif

    logic accept;
    logic aw_done;
    logic w_done;
    logic b_hs;

    // Handshake qualifiers; in_ready_q gates accept so nothing is taken on the first edge after reset.
    always_comb begin
        accept  = (state_q == ST_IDLE) && in_valid && in_ready_q;
        aw_done = !awvalid_q || m_axil_awready;
        w_done  = !wvalid_q || m_axil_wready;
        b_hs    = (state_q == ST_WAIT_B) && bready_q && m_axil_bvalid;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SEND;
            ST_SEND:   if (aw_done && w_done) state_d = ST_WAIT_B;
`ifdef SB_AXIL_WR_RESP_EN
            ST_WAIT_B: if (b_hs) state_d = ST_RESP;
            ST_RESP:   if (resp_ready) state_d = ST_IDLE;
`else
            ST_WAIT_B: if (b_hs) state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and payload.
    always_comb begin
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        bready_d   = (state_d == ST_WAIT_B);
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
`ifdef SB_AXIL_WR_RESP_EN
        resp_valid_d = (state_d == ST_RESP);
        resp_code_d  = resp_code_q;
`endif
        if (accept) begin
            addr_d    = in_addr;
            data_d    = in_data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (b_hs) begin
            if (wr_cnt_q != {CNT_WIDTH{1'b1}}) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
            if ((m_axil_bresp != 2'b00) && (err_cnt_q != {CNT_WIDTH{1'b1}}))
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
`ifdef SB_AXIL_WR_RESP_EN
            resp_code_d = m_axil_bresp;
`endif
        end
    end

    // Output, payload and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_ready_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
`ifdef SB_AXIL_WR_RESP_EN
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
`endif
        end else begin
            in_ready_q <= in_ready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
`ifdef SB_AXIL_WR_RESP_EN
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
`endif
        end
    end

    assign in_ready       = in_ready_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = {STRB_WIDTH{1'b1}};
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign busy           = busy_q;
    assign wr_count       = wr_cnt_q;
    assign err_count      = err_cnt_q;
`ifdef SB_AXIL_WR_RESP_EN
    assign resp_valid     = resp_valid_q;
    assign resp_code      = resp_code_q;
`endif

endmodule

// File: tb/tb_axil_stream_writer.sv
// Directed bench for axil_stream_writer: a 16-bit-counter instance plus a
// 2-bit-counter instance driven by the same stimulus for saturation checks.
module tb_axil_stream_writer;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;

    logic        in_ready, awvalid, wvalid, bready, busy;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic [15:0] wr_count, err_count;

    logic        s_in_ready, s_awvalid, s_wvalid, s_bready, s_busy;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_wr_count, s_err_count;

`ifdef SB_AXIL_WR_RESP_EN
    logic        resp_ready;
    logic        resp_valid, s_resp_valid;
    logic [1:0]  resp_code, s_resp_code;
`endif

    int n_pass  = 0;
    int n_total = 0;

    axil_stream_writer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_bresp(bresp), .busy(busy), .wr_count(wr_count), .err_count(err_count)
`ifdef SB_AXIL_WR_RESP_EN
        , .resp_valid(resp_valid), .resp_code(resp_code), .resp_ready(resp_ready)
`endif
    );

    axil_stream_writer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_addr(in_addr), .in_data(in_data),
        .m_axil_awaddr(s_awaddr), .m_axil_awvalid(s_awvalid), .m_axil_awready(awready),
        .m_axil_wdata(s_wdata), .m_axil_wstrb(s_wstrb), .m_axil_wvalid(s_wvalid),
        .m_axil_wready(wready), .m_axil_bvalid(bvalid), .m_axil_bready(s_bready),
        .m_axil_bresp(bresp), .busy(s_busy), .wr_count(s_wr_count), .err_count(s_err_count)
`ifdef SB_AXIL_WR_RESP_EN
        , .resp_valid(s_resp_valid), .resp_code(s_resp_code), .resp_ready(resp_ready)
`endif
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        in_valid = 1'b0; in_addr = '0; in_data = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Drives one command through a slave with configurable AW/W ready latency.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input int aw_lat, input int w_lat, input logic [1:0] resp);
        int  aw_n, w_n, guard;
        bit  aw_done, w_done, b_done, aw_hs, w_hs, b_hs;
        aw_n = 0; w_n = 0; guard = 0;
        aw_done = 0; w_done = 0; b_done = 0;
        in_valid = 1'b1; in_addr = a; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        while (!b_done && guard < 64) begin
            awready = !aw_done && awvalid && (aw_n >= aw_lat);
            wready  = !w_done && wvalid && (w_n >= w_lat);
            bvalid  = aw_done && w_done;
            bresp   = resp;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            if (awvalid) aw_n++;
            if (wvalid)  w_n++;
            @(negedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (b_hs)  b_done = 1;
            guard++;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
`ifdef SB_AXIL_WR_RESP_EN
        @(negedge clk);
`endif
        n_total++;
        if (!b_done) $display("FAIL write_timeout: got no B handshake, want one within 64 cycles");
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if ({awvalid, wvalid, bready, busy} !== 4'b0000)
            $display("FAIL reset_valids: got %b want 0000", {awvalid, wvalid, bready, busy}); else n_pass++;
        n_total++; if ({wr_count, err_count, awaddr, wdata} !== '0)
            $display("FAIL reset_regs: got %h want 0", {wr_count, err_count, awaddr, wdata}); else n_pass++;
        n_total++; if (wstrb !== 4'hF) $display("FAIL wstrb: got %h want f", wstrb); else n_pass++;
        resetn = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL in_ready_before_edge: got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL in_ready_after_edge: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        in_valid = 1'b1; in_addr = 32'h2000_0000; in_data = 32'h0000_0001;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL single_valids: got %b want 11", {awvalid, wvalid}); else n_pass++;
        n_total++; if (awaddr !== 32'h2000_0000) $display("FAIL single_awaddr: got %h want 20000000", awaddr); else n_pass++;
        n_total++; if (wdata !== 32'h0000_0001) $display("FAIL single_wdata: got %h want 00000001", wdata); else n_pass++;
        n_total++; if ({in_ready, busy, bready} !== 3'b010) $display("FAIL single_send: got %b want 010", {in_ready, busy, bready}); else n_pass++;
        @(negedge clk);
        n_total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL single_waitb: got %b want 001", {awvalid, wvalid, bready}); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL single_waitb_in_ready: got %b want 0", in_ready); else n_pass++;
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        n_total++; if (bready !== 1'b0) $display("FAIL single_bready_pulse: got %b want 0", bready); else n_pass++;
`ifdef SB_AXIL_WR_RESP_EN
        n_total++; if ({resp_valid, resp_code} !== 3'b100) $display("FAIL single_resp: got %b want 100", {resp_valid, resp_code}); else n_pass++;
        @(negedge clk);
`endif
        n_total++; if ({in_ready, busy} !== 2'b10) $display("FAIL single_back_idle: got %b want 10", {in_ready, busy}); else n_pass++;
        n_total++; if (wr_count !== 16'd1 || err_count !== 16'd0)
            $display("FAIL single_counts: got wr=%0d err=%0d want wr=1 err=0", wr_count, err_count); else n_pass++;
        awready = 1'b0; wready = 1'b0;
    endtask

    // delay_aw=1: AW ready held off for 3 cycles; delay_aw=0: W ready held off.
    task automatic test_skew(input bit delay_aw);
        logic slow_v, fast_v;
        apply_reset();
        in_valid = 1'b1; in_addr = 32'h0000_1234; in_data = 32'hCAFE_F00D;
        awready = !delay_aw; wready = delay_aw;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL skew%0d_start: got %b want 11", delay_aw, {awvalid, wvalid}); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            slow_v = delay_aw ? awvalid : wvalid;
            fast_v = delay_aw ? wvalid : awvalid;
            n_total++; if ({slow_v, fast_v, bready} !== 3'b100)
                $display("FAIL skew%0d_hold%0d: got slow/fast/bready %b want 100", delay_aw, c, {slow_v, fast_v, bready}); else n_pass++;
            n_total++; if (awaddr !== 32'h0000_1234 || wdata !== 32'hCAFE_F00D)
                $display("FAIL skew%0d_stable%0d: got %h/%h want 00001234/cafef00d", delay_aw, c, awaddr, wdata); else n_pass++;
        end
        if (delay_aw) awready = 1'b1; else wready = 1'b1;
        @(negedge clk);
        n_total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL skew%0d_waitb: got %b want 001", delay_aw, {awvalid, wvalid, bready}); else n_pass++;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
`ifdef SB_AXIL_WR_RESP_EN
        @(negedge clk);
`endif
        n_total++; if ({wr_count, busy} !== {16'd1, 1'b0}) $display("FAIL skew%0d_done: got wr=%0d busy=%b want 1/0", delay_aw, wr_count, busy); else n_pass++;
    endtask

    task automatic test_error();
        apply_reset();
        do_write(32'h100, 32'h11, 0, 0, 2'b00);
        do_write(32'h104, 32'h22, 1, 0, 2'b10);
        do_write(32'h108, 32'h33, 0, 2, 2'b00);
        n_total++; if (wr_count !== 16'd3) $display("FAIL error_wr_count: got %0d want 3", wr_count); else n_pass++;
        n_total++; if (err_count !== 16'd1) $display("FAIL error_err_count: got %0d want 1", err_count); else n_pass++;
    endtask

    task automatic test_early_bvalid();
        apply_reset();
        in_valid = 1'b1; in_addr = 32'h40; in_data = 32'h44;
        awready = 1'b0; wready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        n_total++; if (bready !== 1'b0) $display("FAIL early_bready_send0: got %b want 0", bready); else n_pass++;
        @(negedge clk);
        n_total++; if ({bready, awvalid} !== 2'b01) $display("FAIL early_bready_send1: got %b want 01", {bready, awvalid}); else n_pass++;
        n_total++; if (wr_count !== 16'd0) $display("FAIL early_no_count: got %0d want 0", wr_count); else n_pass++;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        n_total++; if (bready !== 1'b1) $display("FAIL early_bready_waitb: got %b want 1", bready); else n_pass++;
        @(negedge clk);
        bvalid = 1'b0; wready = 1'b0;
        n_total++; if ({wr_count, bready} !== {16'd1, 1'b0}) $display("FAIL early_one_count: got wr=%0d bready=%b want 1/0", wr_count, bready); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (wr_count !== 16'd1) $display("FAIL early_no_dup: got %0d want 1", wr_count); else n_pass++;
    endtask

    task automatic test_hold_valid();
        apply_reset();
        in_valid = 1'b1; in_addr = 32'h80; in_data = 32'h88;
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
`ifdef SB_AXIL_WR_RESP_EN
        @(negedge clk);
`endif
        in_valid = 1'b0;
        n_total++; if ({wr_count, in_ready} !== {16'd1, 1'b1}) $display("FAIL hold_one_write: got wr=%0d in_ready=%b want 1/1", wr_count, in_ready); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if ({wr_count, busy, awvalid} !== {16'd1, 2'b00}) $display("FAIL hold_no_dup: got wr=%0d busy=%b aw=%b want 1/0/0", wr_count, busy, awvalid); else n_pass++;
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) do_write(32'h200 + 32'(i * 4), 32'(i), 0, 0, 2'b11);
        n_total++; if ({s_wr_count, s_err_count} !== 4'b1111)
            $display("FAIL sat_counts: got wr=%0d err=%0d want 3/3", s_wr_count, s_err_count); else n_pass++;
        n_total++; if ({wr_count, err_count} !== {16'd5, 16'd5})
            $display("FAIL wide_counts: got wr=%0d err=%0d want 5/5", wr_count, err_count); else n_pass++;
        n_total++; if ({s_in_ready, s_busy, s_awvalid, s_wvalid, s_bready} !== 5'b10000)
            $display("FAIL sat_idle: got %b want 10000", {s_in_ready, s_busy, s_awvalid, s_wvalid, s_bready}); else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_write(32'h300, 32'h3, 0, 0, 2'b10);
        in_valid = 1'b1; in_addr = 32'h304; in_data = 32'h4;
        awready = 1'b0; wready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if ({awvalid, busy, wr_count, err_count} !== {2'b11, 16'd1, 16'd1})
            $display("FAIL areset_pre: got aw=%b busy=%b wr=%0d err=%0d want 1/1/1/1", awvalid, busy, wr_count, err_count); else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_total++; if ({awvalid, wvalid, bready, busy, in_ready} !== 5'b00000)
            $display("FAIL areset_valids: got %b want 00000", {awvalid, wvalid, bready, busy, in_ready}); else n_pass++;
        n_total++; if ({wr_count, err_count} !== 32'd0)
            $display("FAIL areset_counts: got wr=%0d err=%0d want 0/0", wr_count, err_count); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_total++; if ({in_ready, busy} !== 2'b10) $display("FAIL areset_recover: got %b want 10", {in_ready, busy}); else n_pass++;
    endtask

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
`ifdef SB_AXIL_WR_RESP_EN
        resp_ready = 1'b1;
`endif
        idle_inputs();
        test_reset();
        test_single();
        test_skew(1'b1);
        test_skew(1'b0);
        test_error();
        test_early_bvalid();
        test_hold_valid();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
